// File: rtl/palette_ram_cycler.sv
// palette_ram_cycler: writable RGB palette with 2-stage lookup, write forwarding, transparency key and colour cycling
module palette_ram_cycler #(
  parameter int INDEX_W      = 4,
  parameter int CH_W         = 4,
  parameter int TRANSP_INDEX = 0,
  parameter int CYCLE_START  = 8,
  parameter int CYCLE_LEN    = 3,
  parameter int CYCLE_PERIOD = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                cycle_en,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                pix_valid,
  input  logic [INDEX_W-1:0]  index,
  input  logic                blank,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                transparent
);
  localparam int DW = 3 * CH_W;
  localparam int N = 2 ** INDEX_W;
  localparam int XW = INDEX_W + 1;
  localparam int FW = $clog2(CYCLE_PERIOD + 1);
  localparam logic [XW-1:0] cs = XW'(CYCLE_START);
  localparam logic [XW-1:0] cl = XW'(CYCLE_LEN);
  localparam logic [INDEX_W-1:0] ti = INDEX_W'(TRANSP_INDEX);
  localparam logic [FW-1:0] pl = FW'(CYCLE_PERIOD - 1);
  logic [DW-1:0] pal [N];
  logic [XW-1:0] off, ext, rel, sum, wrap;
  logic [FW-1:0] fcnt;
  logic in_rng;
  logic [INDEX_W-1:0] remap;
  logic s1_v, s1_b, s1_t;
  logic [INDEX_W-1:0] s1_idx;
  logic [DW-1:0] rd;
  // rel and off are both below CYCLE_LEN, so one conditional subtract implements the modulo
  always_comb begin
    ext = {1'b0, index};
    in_rng = (ext >= cs) && (ext < cs + cl);
    rel = ext - cs;
    sum = rel + off;
    wrap = (sum >= cl) ? sum - cl : sum;
    remap = in_rng ? INDEX_W'(cs + wrap) : index;
    rd = (wr_en && wr_addr == s1_idx) ? wr_data : pal[s1_idx];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) pal[i] <= '0;
      off <= '0;
      fcnt <= '0;
      s1_v <= 1'b0;
      s1_b <= 1'b0;
      s1_t <= 1'b0;
      s1_idx <= '0;
      out_valid <= 1'b0;
      red <= '0;
      green <= '0;
      blue <= '0;
      transparent <= 1'b0;
    end else begin
      if (wr_en) pal[wr_addr] <= wr_data;
      if (cycle_en && frame_start) begin
        fcnt <= (fcnt == pl) ? '0 : fcnt + 1'b1;
        if (fcnt == pl) off <= (off == cl - 1'b1) ? '0 : off + 1'b1;
      end
      s1_v <= pix_valid;
      s1_b <= blank;
      s1_t <= (index == ti);
      s1_idx <= remap;
      out_valid <= s1_v;
      if (s1_v) begin
        {red, green, blue} <= (s1_b || s1_t) ? '0 : rd;
        transparent <= s1_t && !s1_b;
      end
    end
  end
endmodule

// File: tb/tb_palette_ram_cycler.sv
// tb_palette_ram_cycler: directed test-plan steps plus random traffic against a cycle-level palette model
module tb_palette_ram_cycler;
  localparam int IW = 4, CW = 4, DW = 12;
  localparam int CS = 8, CL = 3, CP = 2, TI = 0;
  logic Clk = 1'b0;
  logic Reset, frame_start, cycle_en, wr_en, pix_valid, blank;
  logic [IW-1:0] wr_addr, index;
  logic [DW-1:0] wr_data;
  logic out_valid, transparent;
  logic [CW-1:0] red, green, blue;
  int checks = 0, errors = 0;
  logic [DW-1:0] m_pal [16];
  int m_off, m_cnt, s_idx;
  logic s_v, s_b, s_t, e_v, e_t;
  logic [DW-1:0] e_rgb, got_rgb;
  logic got_t;

  always #5 Clk = ~Clk;

  palette_ram_cycler dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .cycle_en(cycle_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pix_valid(pix_valid),
    .index(index), .blank(blank), .out_valid(out_valid), .red(red), .green(green),
    .blue(blue), .transparent(transparent)
  );

  function automatic int remap(int i, int off);
    if (i >= CS && i < CS + CL) return CS + (i - CS + off) % CL;
    return i;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock: predict from the pre-edge inputs, then compare every output after the edge
  task automatic cyc();
    logic nv, nt;
    logic [DW-1:0] nrgb;
    nv = e_v; nt = e_t; nrgb = e_rgb;
    if (Reset) begin
      for (int i = 0; i < 16; i++) m_pal[i] = '0;
      m_off = 0; m_cnt = 0; s_v = 0; s_b = 0; s_t = 0; s_idx = 0;
      nv = 0; nt = 0; nrgb = '0;
    end else begin
      nv = s_v;
      if (s_v) begin
        nt = s_t && !s_b;
        nrgb = (s_b || s_t) ? '0 : (wr_en && int'(wr_addr) == s_idx) ? wr_data : m_pal[s_idx];
      end
      s_v = pix_valid; s_b = blank; s_t = (int'(index) == TI);
      s_idx = remap(int'(index), m_off);
      if (wr_en) m_pal[wr_addr] = wr_data;
      if (cycle_en && frame_start) begin
        m_cnt++;
        if (m_cnt == CP) begin
          m_cnt = 0;
          m_off = (m_off + 1) % CL;
        end
      end
    end
    @(posedge Clk);
    #1;
    e_v = nv; e_t = nt; e_rgb = nrgb;
    check("out_valid", 32'(out_valid), 32'(e_v));
    check("rgb", 32'({red, green, blue}), 32'(e_rgb));
    check("transparent", 32'(transparent), 32'(e_t));
  endtask

  task automatic idle(int n);
    pix_valid = 0; wr_en = 0; frame_start = 0;
    repeat (n) cyc();
  endtask

  task automatic write(int a, logic [DW-1:0] d);
    wr_en = 1; wr_addr = IW'(a); wr_data = d;
    cyc();
    wr_en = 0;
  endtask

  task automatic lookup(int i, logic b, output logic [DW-1:0] rgb, output logic t);
    pix_valid = 1; index = IW'(i); blank = b;
    cyc();
    pix_valid = 0; blank = 0;
    check("lat_early", 32'(out_valid), 32'd0);
    cyc();
    check("lat_valid", 32'(out_valid), 32'd1);
    rgb = {red, green, blue}; t = transparent;
    cyc();
    check("lat_after", 32'(out_valid), 32'd0);
  endtask

  task automatic pulses(int n);
    repeat (n) begin
      frame_start = 1; cyc();
      frame_start = 0; cyc();
    end
  endtask

  initial begin
    Reset = 1; frame_start = 0; cycle_en = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    pix_valid = 0; index = 0; blank = 0;
    cyc(); cyc();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_rgb", 32'({red, green, blue}), 32'd0);
    Reset = 0;
    idle(1);
    write(3, 12'hFFF);
    lookup(3, 0, got_rgb, got_t);
    check("t1_rgb", 32'(got_rgb), 32'hFFF);
    check("t1_transp", 32'(got_t), 32'd0);
    write(0, 12'hC40);
    lookup(0, 0, got_rgb, got_t);
    check("t2_rgb", 32'(got_rgb), 32'h000);
    check("t2_transp", 32'(got_t), 32'd1);
    lookup(0, 1, got_rgb, got_t);
    check("t2_blank_rgb", 32'(got_rgb), 32'h000);
    check("t2_blank_transp", 32'(got_t), 32'd0);
    write(8, 12'h3BF); write(9, 12'h59F); write(10, 12'hF93); write(5, 12'h123);
    cycle_en = 1;
    lookup(8, 0, got_rgb, got_t); check("t3_p0", 32'(got_rgb), 32'h3BF);
    lookup(5, 0, got_rgb, got_t); check("t3_i5_p0", 32'(got_rgb), 32'h123);
    pulses(2);
    lookup(8, 0, got_rgb, got_t); check("t3_p2", 32'(got_rgb), 32'h59F);
    lookup(5, 0, got_rgb, got_t); check("t3_i5_p2", 32'(got_rgb), 32'h123);
    pulses(2);
    lookup(8, 0, got_rgb, got_t); check("t3_p4", 32'(got_rgb), 32'hF93);
    pulses(2);
    lookup(8, 0, got_rgb, got_t); check("t3_p6", 32'(got_rgb), 32'h3BF);
    lookup(5, 0, got_rgb, got_t); check("t3_i5_p6", 32'(got_rgb), 32'h123);
    write(5, 12'h000);
    pix_valid = 1; index = 5; cyc();
    pix_valid = 0; wr_en = 1; wr_addr = 5; wr_data = 12'h0A0; cyc();
    wr_en = 0;
    check("t4_fwd_valid", 32'(out_valid), 32'd1);
    check("t4_fwd_rgb", 32'({red, green, blue}), 32'h0A0);
    idle(1);
    write(5, 12'h000);
    pix_valid = 1; index = 5; cyc();
    pix_valid = 0; wr_en = 1; wr_addr = 6; wr_data = 12'h0A0; cyc();
    wr_en = 0;
    check("t4_nofwd_rgb", 32'({red, green, blue}), 32'h000);
    idle(1);
    cycle_en = 0;
    pulses(5);
    lookup(8, 0, got_rgb, got_t); check("t5_hold", 32'(got_rgb), 32'h3BF);
    cycle_en = 1;
    pulses(2);
    lookup(8, 0, got_rgb, got_t); check("t5_step", 32'(got_rgb), 32'h59F);
    lookup(9, 0, got_rgb, got_t); check("t5_step9", 32'(got_rgb), 32'hF93);
    pix_valid = 1; index = 8; cyc();
    index = 9; cyc();
    Reset = 1; index = 10; cyc();
    Reset = 0; pix_valid = 0;
    check("t6_after_reset", 32'(out_valid), 32'd0);
    cyc();
    check("t6_discard", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      lookup(i, 0, got_rgb, got_t);
      check("t6_cleared", 32'(got_rgb), 32'h000);
    end
    write(8, 12'h3BF); write(9, 12'h59F); write(10, 12'hF93);
    lookup(8, 0, got_rgb, got_t); check("t6_offset0", 32'(got_rgb), 32'h3BF);
    for (int k = 0; k < 600; k++) begin
      Reset = ($urandom_range(0, 79) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      cycle_en = ($urandom_range(0, 5) != 0);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = IW'($urandom_range(0, 15));
      wr_data = DW'($urandom);
      pix_valid = $urandom_range(0, 1) == 1;
      index = ($urandom_range(0, 1) == 1) ? IW'($urandom_range(7, 11)) : IW'($urandom_range(0, 15));
      blank = ($urandom_range(0, 5) == 0);
      cyc();
    end
    Reset = 0;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
